step_sequencer_disp: RTL and testbench
======================================

# step_sequencer_disp

Parametrised step sequencer with a multiplexed seven-segment readout. An internal divider produces a step tick every CLK_DIV clock cycles. On each tick a 4×DIGITS-bit count advances by a run-time-selected mode: up, down, up-by-3 or hold. The count is shown as hex on DIGITS time-multiplexed active-low digits. It replaces the fixed 2-bit sequencer/decoder pair in the board-level lab top and drops straight onto the board clock.

## Interface
- CLK_DIV, 25000000, clk cycles per step tick; must be ≥1.
- DIGITS, 2, number of hex digits; count width W = 4×DIGITS.
- SCAN_DIV, 50000, clk cycles each digit is driven before the scan advances; must be ≥1.
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  step mode: 00 = +1, 01 = −1, 10 = +3, 11 = hold. Sampled at the tick edge.
- load  in  1  synchronous load strobe.
- load_val  in  W  value loaded into the count.
- count  out  W  current count, registered.
- step  out  1  one-cycle pulse, registered; high in the cycle after the count changes by a tick.
- wrap  out  1  one-cycle pulse, registered; high with step when the step crossed the modulo-2^W boundary.
- an  out  DIGITS  digit enables, active-low, one-hot-low while scanning.
- out  out  7  segments gfedcba, active-low.

## Operation
- Divider: div_cnt counts 0..CLK_DIV−1 and wraps. A tick occurs at the edge where div_cnt == CLK_DIV−1.
- Tick with load=0:
  - mode 00: count ← count+1 mod 2^W.
  - mode 01: count ← count−1 mod 2^W.
  - mode 10: count ← count+3 mod 2^W.
  - For modes 00/01/10: step ← 1; wrap ← carry/borrow out of the W-bit add.
  - mode 11: count unchanged, step ← 0, wrap ← 0.
- Load (any edge with load=1):
  - count ← load_val; div_cnt ← 0; step ← 0; wrap ← 0.
  - Load has priority over a coincident tick; that tick is lost.
- step and wrap are 0 on every edge without a mode-00/01/10 tick.
- Mode changes between ticks have no effect until the next tick edge.
- Scan:
  - scan_cnt counts 0..SCAN_DIV−1. When it wraps, dig_idx advances 0→1→…→DIGITS−1→0.
  - Each edge: an ← all-ones except bit dig_idx = 0; out ← hex7seg(count[4·dig_idx+3 : 4·dig_idx]).
- hex7seg (gfedcba, active-low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Reset asserted (lamp test):
  - count = 0, div_cnt = 0, scan_cnt = 0, dig_idx = 0, step = 0, wrap = 0.
  - an = all 0, out = 7'b0000000 (every segment lit).
  - These values are held for as long as reset is low; assertion is immediate, not clock-gated.

## Timing
- After reset release, the first tick is on the CLK_DIV-th rising edge. count updates at that edge; step/wrap are high for the following cycle only.
- Tick-to-tick spacing is exactly CLK_DIV cycles. A load restarts it: the next tick is CLK_DIV edges after the load edge.
- an/out lag count and dig_idx by one cycle (registered decode).
- Each digit is enabled for exactly SCAN_DIV cycles per scan; the full frame is DIGITS×SCAN_DIV cycles.
- With CLK_DIV = 1 the count steps on every edge and step stays high continuously while mode ≠ 11.
- Reset mid-operation discards any in-progress divider or scan position. No partial step is ever visible.

## Configuration
- BLANK_LEADING_ZERO_EN defined: for dig_idx > 0, out = 7'b1111111 (blank) when that nibble and every higher nibble are zero. Digit 0 is always shown. an scanning is unchanged.
- Not defined: every digit always shows its hex value, including leading zeros.

## Test plan
All scenarios use CLK_DIV=4, DIGITS=2, SCAN_DIV=2.
- Reset then release, mode=00 → count 0x00 for 3 edges, 0x01 on edge 4 with step=1 for 1 cycle, 0x02 on edge 8. During reset: an=2'b00, out=7'b0000000.
- load_val=0xFE, mode=00 → ticks give 0xFF then 0x00, with wrap=1 and step=1 on the 0x00 step only.
- count=0x00, mode=01 → 0xFF with wrap=1. Then mode=10 from 0xFE → 0x01 with wrap=1. Then mode=11 → count frozen, step=0 across 3 ticks.
- load asserted on the tick edge with load_val=0x5A → count=0x5A, step=0. The next change is 4 edges later, to 0x5B.
- count=0x3C → an alternates 2'b10 / 2'b01 every 2 cycles with out=1000110 (C) / 0110000 (3). count=0x07 with BLANK_LEADING_ZERO_EN → digit 1 out=1111111, digit 0 out=1111000.
- reset pulsed low mid-scan and mid-divider → all outputs take reset values immediately. After release, the first tick is again 4 edges later.

Source files
------------

// File: rtl/step_sequencer_disp_if.sv
// Control and display bundle for step_sequencer_disp: mode/load inputs, count/pulse/segment outputs.
// Combinational wiring only; no flow control, outputs are continuously valid.
interface step_sequencer_disp_if #(
   parameter int DIGITS = 2
);
   logic [1:0]          mode;
   logic                load;
   logic [4*DIGITS-1:0] load_val;
   logic [4*DIGITS-1:0] count;
   logic                step;
   logic                wrap;
   logic [DIGITS-1:0]   an;
   logic [6:0]          out;

   modport master (
      output mode, load, load_val,
      input  count, step, wrap, an, out
   );

   modport slave (
      input  mode, load, load_val,
      output count, step, wrap, an, out
   );
endinterface

// File: rtl/step_sequencer_disp.sv
// Tick-driven hex counter (up/down/+3/hold) with a multiplexed active-low seven-segment readout.
// Latency: count updates on the tick edge, step/wrap one cycle later, an/out one cycle behind count.
// No backpressure; optional BLANK_LEADING_ZERO_EN blanks zero-valued upper digits.
module step_sequencer_disp #(
   parameter int CLK_DIV  = 25000000,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   step_sequencer_disp_if.slave bus
);
   localparam int W      = 4 * DIGITS;
   localparam int DIV_W  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [W:0]        STEP_ONE   = (W+1)'(1);
   localparam logic [W:0]        STEP_THREE = (W+1)'(3);

   typedef enum logic [1:0] {
      MODE_INC  = 2'b00,
      MODE_DEC  = 2'b01,
      MODE_INC3 = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   logic [W-1:0]      count_q,    count_d;
   logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
   logic              step_q,     step_d;
   logic              wrap_q,     wrap_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]  dig_idx_q,  dig_idx_d;
   logic [DIGITS-1:0] an_q,       an_d;
   logic [6:0]        out_q,      out_d;

   logic              tick;
   logic [W:0]        sum_ext;
   logic [3:0]        nib_sel;
`ifdef BLANK_LEADING_ZERO_EN
   logic              upper_zero;
`endif

   function automatic logic [6:0] hex7seg(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // Divider and count: load wins over a coincident tick and restarts the divider.
   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      count_d   = count_q;
      step_d    = 1'b0;
      wrap_d    = 1'b0;
      sum_ext   = {1'b0, count_q};

      unique case (mode_e'(bus.mode))
         MODE_INC:  sum_ext = {1'b0, count_q} + STEP_ONE;
         MODE_DEC:  sum_ext = {1'b0, count_q} - STEP_ONE;
         MODE_INC3: sum_ext = {1'b0, count_q} + STEP_THREE;
         MODE_HOLD: sum_ext = {1'b0, count_q};
      endcase

      if (bus.load) begin
         count_d   = bus.load_val;
         div_cnt_d = '0;
      end else if (tick && (mode_e'(bus.mode) != MODE_HOLD)) begin
         count_d = sum_ext[W-1:0];
         step_d  = 1'b1;
         // Bit W is the carry for additions and the borrow for the decrement.
         wrap_d  = sum_ext[W];
      end
   end

   // Scan position and registered digit decode from the current count and digit index.
   always_comb begin
      scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);
      dig_idx_d  = dig_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
      end

      nib_sel = count_q[3:0];
`ifdef BLANK_LEADING_ZERO_EN
      upper_zero = 1'b0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_idx_q == IDX_W'(i)) begin
            nib_sel = count_q[4*i +: 4];
`ifdef BLANK_LEADING_ZERO_EN
            upper_zero = (i > 0) && ((count_q >> (4*i)) == '0);
`endif
         end
      end

      an_d  = ~(DIGITS'(1) << dig_idx_q);
      out_d = hex7seg(nib_sel);
`ifdef BLANK_LEADING_ZERO_EN
      if (upper_zero) begin
         out_d = 7'b1111111;
      end
`endif
   end

   // Reset is the lamp test: all digits enabled, all segments lit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q    <= '0;
         div_cnt_q  <= '0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
         scan_cnt_q <= '0;
         dig_idx_q  <= '0;
         an_q       <= '0;
         out_q      <= '0;
      end else begin
         count_q    <= count_d;
         div_cnt_q  <= div_cnt_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
         scan_cnt_q <= scan_cnt_d;
         dig_idx_q  <= dig_idx_d;
         an_q       <= an_d;
         out_q      <= out_d;
      end
   end

   assign bus.count = count_q;
   assign bus.step  = step_q;
   assign bus.wrap  = wrap_q;
   assign bus.an    = an_q;
   assign bus.out   = out_q;

endmodule

// File: tb/tb_step_sequencer_disp.sv
// Scoreboard bench for step_sequencer_disp: directed scenarios then random mode/load/reset traffic.
module tb_step_sequencer_disp;
   localparam int CLK_DIV  = 4;
   localparam int DIGITS   = 2;
   localparam int SCAN_DIV = 2;

   typedef struct packed {
      logic [7:0] count;
      logic       step;
      logic       wrap;
      logic [1:0] an;
      logic [6:0] out;
   } exp_t;

   logic clk;
   logic reset;
   step_sequencer_disp_if #(.DIGITS(DIGITS)) bus ();

   step_sequencer_disp #(
      .CLK_DIV (CLK_DIV),
      .DIGITS  (DIGITS),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] seg_tab [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Reference state: plain integers for the count, edge counters for divider phase and scan position.
   int         m_count;
   bit         m_step, m_wrap;
   logic [1:0] m_an;
   logic [6:0] m_out;
   int         m_div;
   int         m_scan;

   function automatic logic [6:0] seg_of(input int value, input int d);
      int upper;
      upper = value >> (4*d);
`ifdef BLANK_LEADING_ZERO_EN
      if (d > 0 && upper == 0) return 7'b1111111;
`endif
      return seg_tab[upper % 16];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   task automatic model_edge(input logic [1:0] md, input logic ld, input logic [7:0] lv, input logic in_rst);
      int d, nv, delta;
      exp_t e;
      if (in_rst) begin
         m_count = 0; m_step = 0; m_wrap = 0;
         m_an = 2'b00; m_out = 7'b0000000;
         m_div = 0; m_scan = 0;
      end else begin
         d = (m_scan / SCAN_DIV) % DIGITS;
         m_an = 2'b11;
         m_an[d] = 1'b0;
         m_out = seg_of(m_count, d);
         m_scan++;
         m_div++;
         if (ld) begin
            m_count = int'(lv); m_div = 0; m_step = 0; m_wrap = 0;
         end else if ((m_div % CLK_DIV) == 0 && md != 2'b11) begin
            delta = (md == 2'b00) ? 1 : (md == 2'b01) ? -1 : 3;
            nv = m_count + delta;
            m_wrap = (nv < 0) || (nv > 255);
            m_count = (nv + 256) % 256;
            m_step = 1;
         end else begin
            m_step = 0; m_wrap = 0;
         end
      end
      e.count = 8'(m_count);
      e.step  = m_step;
      e.wrap  = m_wrap;
      e.an    = m_an;
      e.out   = m_out;
      exp_q.push_back(e);
   endtask

   // Called just after a rising edge; applies inputs for the next edge.
   task automatic step_cyc(input logic [1:0] md, input logic ld, input logic [7:0] lv);
      bus.mode = md; bus.load = ld; bus.load_val = lv;
      @(posedge clk);
      model_edge(md, ld, lv, 1'b0);
      #1;
   endtask

   // Asynchronous assertion replaces the expectation for the cycle already in flight.
   task automatic do_reset(input int n);
      bit had_pending;
      exp_t dummy;
      had_pending = (exp_q.size() > 0);
      reset = 1'b0;
      if (had_pending) dummy = exp_q.pop_back();
      model_edge(2'b00, 1'b0, 8'h00, 1'b1);
      if (!had_pending) dummy = exp_q.pop_back();
      bus.load = 1'b0;
      repeat (n) begin
         @(posedge clk);
         model_edge(2'b00, 1'b0, 8'h00, 1'b1);
         #1;
      end
      reset = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(bus.count), 32'(e.count));
            chk("step",  32'(bus.step),  32'(e.step));
            chk("wrap",  32'(bus.wrap),  32'(e.wrap));
            chk("an",    32'(bus.an),    32'(e.an));
            chk("out",   32'(bus.out),   32'(e.out));
         end
      end
   end

   initial begin : stimulus
      int r;
      reset = 1'b0;
      bus.mode = 2'b00; bus.load = 1'b0; bus.load_val = 8'h00;
      do_reset(3);

      repeat (10) step_cyc(2'b00, 1'b0, 8'h00);

      step_cyc(2'b00, 1'b1, 8'hFE);
      repeat (10) step_cyc(2'b00, 1'b0, 8'h00);

      step_cyc(2'b01, 1'b1, 8'h00);
      repeat (5) step_cyc(2'b01, 1'b0, 8'h00);
      step_cyc(2'b10, 1'b1, 8'hFE);
      repeat (5) step_cyc(2'b10, 1'b0, 8'h00);
      step_cyc(2'b11, 1'b1, 8'h40);
      repeat (14) step_cyc(2'b11, 1'b0, 8'h00);

      for (int k = 0; k < CLK_DIV && ((m_div + 1) % CLK_DIV) != 0; k++)
         step_cyc(2'b00, 1'b0, 8'h00);
      step_cyc(2'b00, 1'b1, 8'h5A);
      repeat (9) step_cyc(2'b00, 1'b0, 8'h00);

      step_cyc(2'b11, 1'b1, 8'h3C);
      repeat (10) step_cyc(2'b11, 1'b0, 8'h00);
      step_cyc(2'b11, 1'b1, 8'h07);
      repeat (6) step_cyc(2'b11, 1'b0, 8'h00);

      step_cyc(2'b00, 1'b1, 8'h10);
      repeat (5) step_cyc(2'b00, 1'b0, 8'h00);
      do_reset(2);
      repeat (10) step_cyc(2'b00, 1'b0, 8'h00);

      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            step_cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0),
                     8'($urandom_range(0, 255)));
         end
      end

      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
